// File: rtl/pe_act_broadcast_engine.sv
// ============================================================================
// Module   : pe_act_broadcast_engine
// Purpose  : Streams a PE's local activations from its register file to the
//            router as broadcast flits, buffered by a 2-entry skid buffer and
//            closed by a terminator flit carrying the sent-flit count.
// Option   : PE_ACT_ZERO_SKIP_EN - drop zero-valued activations
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module pe_act_broadcast_engine #(
   parameter int                      PE_IDX        = 0,
   parameter int                      DATA_W        = 16,
   parameter int                      ACT_NO_W      = 6,
   parameter int                      IDX_W         = 10,
   parameter int                      ROUTER_ADDR_W = 4,
   parameter logic [ROUTER_ADDR_W-1:0] BCAST_ADDR   = '1
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     start,
   input  logic [ACT_NO_W-1:0]      in_act_no,
   input  logic [IDX_W-1:0]         act_base,
   output logic                     rd_en,
   output logic [ACT_NO_W-1:0]      rd_addr,
   input  logic [DATA_W-1:0]        rd_data,
   input  logic                     router_rdy,
   output logic                     send_en,
   output logic [ROUTER_ADDR_W-1:0] send_addr,
   output logic [DATA_W-1:0]        send_data,
   output logic [IDX_W-1:0]         send_idx,
   output logic                     send_last,
   output logic                     busy,
   output logic                     fin_broadcast
);

   // The terminator zero-extends the count into the data field.
   if ((PE_IDX < 0) || (DATA_W < ACT_NO_W)) begin : g_bad_params
      $error("pe_act_broadcast_engine: PE_IDX must be >= 0 and DATA_W >= ACT_NO_W");
   end

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_RUN   = 2'd1,
      S_DRAIN = 2'd2,
      S_TERM  = 2'd3
   } state_t;

   state_t              r_state;
   state_t              w_state_next;

   logic [ACT_NO_W-1:0] r_act_no;
   logic [ACT_NO_W-1:0] r_rd_addr;
   logic [ACT_NO_W-1:0] r_sent;
   logic [IDX_W-1:0]    r_base;
   logic                r_infl;
   logic [IDX_W-1:0]    r_infl_idx;
   logic [DATA_W-1:0]   r_buf_data [2];
   logic [IDX_W-1:0]    r_buf_idx  [2];
   logic                r_head;
   logic [1:0]          r_occ;
   logic                r_fin;

   logic                w_start_ok;
   logic                w_pop;
   logic                w_push;
   logic                w_rd;
   logic                w_last_rd;
   logic                w_term_ack;
   logic                w_tail;
   logic [1:0]          w_occ_eff;
   logic [1:0]          w_occ_next;

   assign w_start_ok = (r_state == S_IDLE) && start;
   assign w_term_ack = (r_state == S_TERM) && router_rdy;
   assign w_pop      = (r_occ != 2'd0) && router_rdy;

`ifdef PE_ACT_ZERO_SKIP_EN
   assign w_push = r_infl && (rd_data != '0);
`else
   assign w_push = r_infl;
`endif

   // Slot freed by this cycle's pop may be refilled, so reads see post-pop occupancy.
   assign w_occ_eff  = r_occ - {1'b0, w_pop};
   assign w_occ_next = w_occ_eff + {1'b0, w_push};
   assign w_rd       = (r_state == S_RUN) && ((w_occ_eff + {1'b0, r_infl}) < 2'd2);
   assign w_last_rd  = w_rd && (r_rd_addr == (r_act_no - 1'b1));
   assign w_tail     = r_head ^ r_occ[0];

   always_comb begin
      w_state_next = r_state;
      case (r_state)
         S_IDLE: begin
            if (start) begin
               w_state_next = (in_act_no != '0) ? S_RUN : S_TERM;
            end
         end
         S_RUN: begin
            if (w_last_rd) begin
               w_state_next = S_DRAIN;
            end
         end
         S_DRAIN: begin
            // No reads are issued here, so after this edge nothing is in flight.
            if (w_occ_next == 2'd0) begin
               w_state_next = S_TERM;
            end
         end
         S_TERM: begin
            if (router_rdy) begin
               w_state_next = S_IDLE;
            end
         end
         default: w_state_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state      <= S_IDLE;
         r_act_no     <= '0;
         r_rd_addr    <= '0;
         r_sent       <= '0;
         r_base       <= '0;
         r_infl       <= 1'b0;
         r_infl_idx   <= '0;
         r_head       <= 1'b0;
         r_occ        <= 2'd0;
         r_fin        <= 1'b0;
         for (int i = 0; i < 2; i++) begin
            r_buf_data[i] <= '0;
            r_buf_idx[i]  <= '0;
         end
      end else begin
         r_state <= w_state_next;
         r_fin   <= w_term_ack;
         r_infl  <= w_rd;
         r_occ   <= w_occ_next;

         if (w_start_ok) begin
            r_act_no  <= in_act_no;
            r_base    <= act_base;
            r_rd_addr <= '0;
            r_sent    <= '0;
         end

         if (w_rd) begin
            r_rd_addr  <= r_rd_addr + 1'b1;
            r_infl_idx <= r_base + IDX_W'(r_rd_addr);
         end

         if (w_pop) begin
            r_head <= ~r_head;
            r_sent <= r_sent + 1'b1;
         end

         if (w_push) begin
            r_buf_data[w_tail] <= rd_data;
            r_buf_idx[w_tail]  <= r_infl_idx;
         end
      end
   end

   assign rd_en         = w_rd;
   assign rd_addr       = r_rd_addr;
   assign send_en       = (r_occ != 2'd0) || (r_state == S_TERM);
   assign send_last     = (r_state == S_TERM);
   assign send_addr     = send_en ? BCAST_ADDR : '0;
   assign send_data     = send_last ? DATA_W'(r_sent) : r_buf_data[r_head];
   assign send_idx      = send_last ? '0 : r_buf_idx[r_head];
   assign busy          = (r_state != S_IDLE);
   assign fin_broadcast = r_fin;

endmodule

`default_nettype wire

// File: tb/tb_pe_act_broadcast_engine.sv
// ============================================================================
// Module   : tb_pe_act_broadcast_engine
// Purpose  : Directed self-checking bench for pe_act_broadcast_engine.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pe_act_broadcast_engine;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic [5:0]  in_act_no;
   logic [9:0]  act_base;
   logic        rd_en;
   logic [5:0]  rd_addr;
   logic [15:0] rd_data;
   logic        router_rdy;
   logic        send_en;
   logic [3:0]  send_addr;
   logic [15:0] send_data;
   logic [9:0]  send_idx;
   logic        send_last;
   logic        busy;
   logic        fin_broadcast;

   logic [15:0] mem [0:63];
   int          n_checks = 0;
   int          n_err    = 0;

   always #5 clk = ~clk;

   // Register-file model: data valid one cycle after rd_en.
   always @(posedge clk) begin
      if (rd_en) rd_data <= mem[rd_addr];
   end

   pe_act_broadcast_engine dut (
      .clk           (clk),
      .rst           (rst),
      .start         (start),
      .in_act_no     (in_act_no),
      .act_base      (act_base),
      .rd_en         (rd_en),
      .rd_addr       (rd_addr),
      .rd_data       (rd_data),
      .router_rdy    (router_rdy),
      .send_en       (send_en),
      .send_addr     (send_addr),
      .send_data     (send_data),
      .send_idx      (send_idx),
      .send_last     (send_last),
      .busy          (busy),
      .fin_broadcast (fin_broadcast)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   // Leaves the bench 1 time unit into the first cycle after start is sampled.
   task automatic start_op(input logic [5:0] n, input logic [9:0] base);
      @(posedge clk);
      #1;
      start     = 1'b1;
      in_act_no = n;
      act_base  = base;
      @(posedge clk);
      #1;
      start     = 1'b0;
   endtask

   task automatic wait_flit(input string tag, input logic [9:0] idx,
                            input logic [15:0] data, input logic last);
      logic found;
      found = 1'b0;
      for (int i = 0; i < 20; i++) begin
         tick();
         if (send_en && router_rdy) begin
            found = 1'b1;
            break;
         end
      end
      chk({tag, "_found"}, found, 1);
      chk({tag, "_idx"},   send_idx, idx);
      chk({tag, "_data"},  send_data, data);
      chk({tag, "_last"},  send_last, last);
      chk({tag, "_addr"},  send_addr, 4'hF);
   endtask

   task automatic check_all_zero(input string tag);
      chk({tag, "_rd_en"},   rd_en, 0);
      chk({tag, "_rd_addr"}, rd_addr, 0);
      chk({tag, "_send_en"}, send_en, 0);
      chk({tag, "_addr"},    send_addr, 0);
      chk({tag, "_data"},    send_data, 0);
      chk({tag, "_idx"},     send_idx, 0);
      chk({tag, "_last"},    send_last, 0);
      chk({tag, "_busy"},    busy, 0);
      chk({tag, "_fin"},     fin_broadcast, 0);
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: observed timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      rst        = 1'b0;
      start      = 1'b0;
      in_act_no  = '0;
      act_base   = '0;
      router_rdy = 1'b1;
      rd_data    = '0;
      for (int i = 0; i < 64; i++) mem[i] = '0;

      // Reset state
      tick();
      tick();
      check_all_zero("reset");
      @(posedge clk);
      #1;
      rst = 1'b1;

      // Basic stream: 4 flits on consecutive cycles, first 2 cycles after start
      mem[0] = 16'd5; mem[1] = 16'd6; mem[2] = 16'd7; mem[3] = 16'd8;
      start_op(6'd4, 10'd8);
      #1;
      chk("t1_rd_en_c1", rd_en, 1);
      chk("t1_busy_c1",  busy, 1);
      chk("t1_send_c1",  send_en, 0);
      tick();
      chk("t1_send_c2",  send_en, 0);
      for (int i = 0; i < 4; i++) begin
         tick();
         chk("t1_flit_en",   send_en, 1);
         chk("t1_flit_idx",  send_idx, 8 + i);
         chk("t1_flit_data", send_data, 5 + i);
         chk("t1_flit_last", send_last, 0);
      end
      tick();
      chk("t1_term_en",   send_en, 1);
      chk("t1_term_last", send_last, 1);
      chk("t1_term_data", send_data, 4);
      chk("t1_term_idx",  send_idx, 0);
      tick();
      chk("t1_fin",  fin_broadcast, 1);
      chk("t1_busy", busy, 0);
      tick();
      chk("t1_fin_pulse", fin_broadcast, 0);

      // Zero activations: terminator only, no reads
      start_op(6'd0, 10'd3);
      #1;
      chk("t2_rd_en",     rd_en, 0);
      chk("t2_term_en",   send_en, 1);
      chk("t2_term_last", send_last, 1);
      chk("t2_term_data", send_data, 0);
      tick();
      chk("t2_fin",    fin_broadcast, 1);
      chk("t2_rd_en2", rd_en, 0);
      chk("t2_busy",   busy, 0);

      // Back-pressure: reads stop with 2 entries stored, head held
      mem[0] = 16'h11; mem[1] = 16'h22; mem[2] = 16'h33;
      router_rdy = 1'b0;
      start_op(6'd3, 10'd0);
      #1;
      chk("t3_rd0", rd_addr, 0);
      tick();
      chk("t3_rd1_en", rd_en, 1);
      chk("t3_rd1",    rd_addr, 1);
      for (int i = 0; i < 6; i++) begin
         tick();
         chk("t3_hold_en",   send_en, 1);
         chk("t3_hold_idx",  send_idx, 0);
         chk("t3_hold_data", send_data, 16'h11);
         chk("t3_hold_rd",   rd_en, 0);
      end
      @(posedge clk);
      #1;
      router_rdy = 1'b1;
      #1;
      chk("t3_rel_idx",  send_idx, 0);
      chk("t3_rel_rd",   rd_en, 1);
      chk("t3_rel_addr", rd_addr, 2);
      wait_flit("t3_f1", 10'd1, 16'h22, 1'b0);
      wait_flit("t3_f2", 10'd2, 16'h33, 1'b0);
      wait_flit("t3_term", 10'd0, 16'd3, 1'b1);
      tick();
      chk("t3_fin", fin_broadcast, 1);

      // Zero-valued activations
      mem[0] = 16'd0; mem[1] = 16'd3; mem[2] = 16'd0; mem[3] = 16'd9;
      start_op(6'd4, 10'd0);
`ifdef PE_ACT_ZERO_SKIP_EN
      wait_flit("t4_f1", 10'd1, 16'd3, 1'b0);
      wait_flit("t4_f3", 10'd3, 16'd9, 1'b0);
      wait_flit("t4_term", 10'd0, 16'd2, 1'b1);
`else
      wait_flit("t4_f0", 10'd0, 16'd0, 1'b0);
      wait_flit("t4_f1", 10'd1, 16'd3, 1'b0);
      wait_flit("t4_f2", 10'd2, 16'd0, 1'b0);
      wait_flit("t4_f3", 10'd3, 16'd9, 1'b0);
      wait_flit("t4_term", 10'd0, 16'd4, 1'b1);
`endif
      tick();
      chk("t4_fin", fin_broadcast, 1);

      // Start while busy is ignored
      mem[0] = 16'd1; mem[1] = 16'd2; mem[2] = 16'd3; mem[3] = 16'd4;
      start_op(6'd4, 10'd0);
      start     = 1'b1;
      in_act_no = 6'd1;
      act_base  = 10'd500;
      @(posedge clk);
      #1;
      start = 1'b0;
      wait_flit("t5_f0", 10'd0, 16'd1, 1'b0);
      wait_flit("t5_f1", 10'd1, 16'd2, 1'b0);
      wait_flit("t5_f2", 10'd2, 16'd3, 1'b0);
      wait_flit("t5_f3", 10'd3, 16'd4, 1'b0);
      wait_flit("t5_term", 10'd0, 16'd4, 1'b1);
      tick();
      chk("t5_fin", fin_broadcast, 1);

      // Reset mid-run aborts with no fin pulse
      start_op(6'd4, 10'd0);
      tick();
      tick();
      chk("t6_pre_send", send_en, 1);
      #1;
      rst = 1'b0;
      #1;
      check_all_zero("t6_async");
      @(posedge clk);
      #1;
      rst = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("t6_no_fin",  fin_broadcast, 0);
         chk("t6_no_busy", busy, 0);
      end

      // Fresh start after abort, index wraps modulo 2^IDX_W
      mem[0] = 16'hA; mem[1] = 16'hB; mem[2] = 16'hC; mem[3] = 16'hD;
      start_op(6'd4, 10'd1022);
      wait_flit("t7_f0", 10'd1022, 16'hA, 1'b0);
      wait_flit("t7_f1", 10'd1023, 16'hB, 1'b0);
      wait_flit("t7_f2", 10'd0,    16'hC, 1'b0);
      wait_flit("t7_f3", 10'd1,    16'hD, 1'b0);
      wait_flit("t7_term", 10'd0,  16'd4, 1'b1);
      tick();
      chk("t7_fin",  fin_broadcast, 1);
      tick();
      chk("t7_idle", busy, 0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
      $finish;
   end

endmodule

`default_nettype wire
